// File: rtl/ram_bist_pkg.sv
// Shared types, phase sequencing helpers and default background word for the
// simple-dual-port RAM march BIST.
package ram_bist_pkg;

  localparam logic [31:0] DEFAULT_PATTERN = 32'h5555_5555;
  localparam int unsigned ERR_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W0_UP   = 3'd1,
    ST_R0W1_UP = 3'd2,
    ST_R1W0_DN = 3'd3,
    ST_R0_DN   = 3'd4,
    ST_GAP     = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_W0_UP   = 2'd0,
    PH_R0W1_UP = 2'd1,
    PH_R1W0_DN = 2'd2,
    PH_R0_DN   = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_W0_UP:   return PH_R0W1_UP;
      PH_R0W1_UP: return PH_R1W0_DN;
      default:    return PH_R0_DN;
    endcase
  endfunction

  function automatic state_e phase_state(input phase_e ph);
    case (ph)
      PH_W0_UP:   return ST_W0_UP;
      PH_R0W1_UP: return ST_R0W1_UP;
      PH_R1W0_DN: return ST_R1W0_DN;
      default:    return ST_R0_DN;
    endcase
  endfunction

  function automatic logic phase_is_down(input phase_e ph);
    return (ph == PH_R1W0_DN) || (ph == PH_R0_DN);
  endfunction

endpackage

// File: rtl/ram_bist_cmp_pipe.sv
// Delays expected data/address alongside the RAM read latency and flags a
// mismatch when the tagged read data returns.
module ram_bist_cmp_pipe
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              mismatch_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [LATENCY-1:0] vld_q;
  logic [ADDR_W-1:0]  addr_q [LATENCY];
  logic [DATA_W-1:0]  exp_q  [LATENCY];

  // NOTE: only the valid tags matter functionally, but the data stages are
  // reset as well so no X ever propagates to the captured failure outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= valid_i;
      addr_q[0] <= addr_i;
      exp_q[0]  <= exp_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign mismatch_o = vld_q[LATENCY-1] && (dout_i != exp_q[LATENCY-1]);
  assign addr_o     = addr_q[LATENCY-1];

endmodule

// File: rtl/ram_sdp_bist_512x32.sv
// March BIST controller for a simple-dual-port RAM: W0 up, R0W1 up, R1W0 down,
// R0 down, with drain gaps between phases and first-failure capture.
module ram_sdp_bist_512x32
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W       = 9,
  parameter int                DATA_W       = 32,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] PATTERN      = DATA_W'(DEFAULT_PATTERN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [ERR_W-1:0]  error_count_o,
  output logic              we_o,
  output logic              re_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [ADDR_W-1:0] read_addr_o,
  output logic [DATA_W-1:0] din_o,
  input  logic [DATA_W-1:0] dout_i
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [1:0]        GAP_LAST  = 2'(READ_LATENCY);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          gap_q, gap_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                done_q, done_d;

  logic                we, re, march;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data, exp_data;
  logic                mm_valid;
  logic [ADDR_W-1:0]   mm_addr;

  ram_bist_cmp_pipe #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_cmp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (re),
    .addr_i     (addr_q),
    .exp_i      (exp_data),
    .dout_i     (dout_i),
    .mismatch_o (mm_valid),
    .addr_o     (mm_addr)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    gap_d       = gap_q;
    wr_pend_d   = 1'b0;
    wr_addr_d   = addr_q;
    wr_data_d   = '0;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    done_d      = 1'b0;
    we          = wr_pend_q;
    wr_addr     = wr_addr_q;
    wr_data     = wr_data_q;
    re          = 1'b0;
    exp_data    = '0;
    march       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_W0_UP;
          phase_d     = PH_W0_UP;
          addr_d      = ADDR_ZERO;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
        end
      end
      ST_W0_UP: begin
        march   = 1'b1;
        we      = 1'b1;
        wr_addr = addr_q;
        wr_data = PATTERN;
      end
      // Read-then-write phases: the write of the complement trails its read by one cycle.
      ST_R0W1_UP: begin
        march     = 1'b1;
        re        = 1'b1;
        exp_data  = PATTERN;
        wr_pend_d = 1'b1;
        wr_data_d = ~PATTERN;
      end
      ST_R1W0_DN: begin
        march     = 1'b1;
        re        = 1'b1;
        exp_data  = ~PATTERN;
        wr_pend_d = 1'b1;
        wr_data_d = PATTERN;
      end
      ST_R0_DN: begin
        march    = 1'b1;
        re       = 1'b1;
        exp_data = PATTERN;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (phase_q == PH_R0_DN) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_q == '0);
            fail_d  = (err_q != '0);
          end else begin
            phase_d = next_phase(phase_q);
            state_d = phase_state(phase_d);
            addr_d  = phase_is_down(phase_d) ? ADDR_MAX : ADDR_ZERO;
          end
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (march) begin
      if (addr_q == (phase_is_down(phase_q) ? ADDR_ZERO : ADDR_MAX)) begin
        state_d = ST_GAP;
        gap_d   = 2'd0;
      end else begin
        addr_d = phase_is_down(phase_q) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
      end
    end

    if (mm_valid) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) begin
        fail_addr_d = mm_addr;
        fail_data_d = dout_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_W0_UP;
      addr_q      <= '0;
      gap_q       <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      gap_q       <= gap_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign fail_addr_o   = fail_addr_q;
  assign fail_data_o   = fail_data_q;
  assign error_count_o = err_q;
  assign we_o          = we;
  assign re_o          = re;
  assign write_addr_o  = wr_addr;
  assign read_addr_o   = addr_q;
  assign din_o         = wr_data;

endmodule
